alu_sequencer: RTL and testbench

Multi-cycle controller sitting between the 6502 decode/control logic and the combinational ALU. It accepts one ALU operation per request, drives the ALU's control and operand inputs, and samples its result. For decimal-mode ADC/SBC it runs a second ALU pass to apply BCD correction. It returns the result with the N/V/Z/C flags computed by the sequencer itself, over a valid/ready handshake.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_bcd_fix.sv | 36 +++
 rtl/alu_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: ALU control codes, 6502 op codes,
// status flag bit positions and sequencer states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_SUM = 3'b000,
    ALU_OR  = 3'b001,
    ALU_XOR = 3'b010,
    ALU_AND = 3'b011,
    ALU_SR  = 3'b100
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    OP_ADC = 4'd0,
    OP_SBC = 4'd1,
    OP_AND = 4'd2,
    OP_ORA = 4'd3,
    OP_EOR = 4'd4,
    OP_CMP = 4'd5,
    OP_ASL = 4'd6,
    OP_LSR = 4'd7,
    OP_ROL = 4'd8,
    OP_ROR = 4'd9
  } op_code_e;

  localparam int FLAG_NEG   = 7;
  localparam int FLAG_OFV   = 6;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_ADJ,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_bcd_fix.sv
// alu_bcd_fix: decimal-adjust term for 6502 ADC/SBC. Produces the constant
// added to the binary result in the second ALU pass and the decimal carry-out.
module alu_bcd_fix (
  input  logic       is_sbc,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  input  logic [7:0] bin_res,
  input  logic       bin_carry,
  output logic [7:0] corr,
  output logic       carry_out
);

  logic [4:0] lo_sum;
  logic [7:0] lo_fix;
  logic [8:0] hi_chk;
  logic       hi_fix;
  logic       lo_borrow;

  always_comb begin
    lo_sum    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, carry_in};
    lo_fix    = (lo_sum > 5'd9) ? 8'h06 : 8'h00;
    hi_chk    = {1'b0, bin_res} + {1'b0, lo_fix};
    hi_fix    = bin_carry | (hi_chk > 9'h099);
    lo_borrow = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'b0, ~carry_in});
    if (is_sbc) begin
      // 0xFA and 0xA0 subtract 6 and 0x60 modulo 256
      corr      = (lo_borrow ? 8'hFA : 8'h00) + (bin_carry ? 8'h00 : 8'hA0);
      carry_out = bin_carry;
    end else begin
      corr      = lo_fix | (hi_fix ? 8'h60 : 8'h00);
      carry_out = hi_fix;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle 6502 ALU controller with request/result handshakes.
// Build option ALU_SEQ_DECIMAL_EN adds the BCD adjust pass for decimal ADC/SBC.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int FLAGS_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [3:0]         op_code,
  input  logic [DW-1:0]      op_a,
  input  logic [DW-1:0]      op_b,
  input  logic               op_carry,
  input  logic               op_decimal,
  output logic [2:0]         alu_ctrl,
  output logic [DW-1:0]      alu_AI,
  output logic [DW-1:0]      alu_BI,
  output logic               alu_carry,
  output logic               alu_DAA,
  input  logic [DW-1:0]      alu_Y,
  input  logic [FLAGS_W-1:0] alu_flags,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DW-1:0]      res_data,
  output logic [FLAGS_W-1:0] res_flags
);

  seq_state_e         state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [DW-1:0]      a_q, a_d, b_q, b_d;
  logic               c_q, c_d;
  logic [DW-1:0]      res_data_q, res_data_d;
  logic [FLAGS_W-1:0] res_flags_q, res_flags_d;
  logic               dec_op;
  logic               b7_eff;
  logic               unused_alu_flags;

  assign unused_alu_flags = ^alu_flags[FLAGS_W-1:1];
  assign b7_eff = (op_q == OP_SBC) ? ~b_q[DW-1] : b_q[DW-1];

`ifdef ALU_SEQ_DECIMAL_EN
  logic          d_q, d_d;
  logic [DW-1:0] adj_corr;
  logic          adj_carry;

  assign dec_op = d_q & ((op_q == OP_ADC) | (op_q == OP_SBC));

  // During ADJ the binary pass result and carry live in the result registers
  alu_bcd_fix u_bcd_fix (
    .is_sbc    (op_q == OP_SBC),
    .a         (a_q),
    .b         (b_q),
    .carry_in  (c_q),
    .bin_res   (res_data_q),
    .bin_carry (res_flags_q[FLAG_CARRY]),
    .corr      (adj_corr),
    .carry_out (adj_carry)
  );
`else
  logic unused_decimal;
  assign unused_decimal = op_decimal;
  assign dec_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
`ifdef ALU_SEQ_DECIMAL_EN
      d_q         <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
`ifdef ALU_SEQ_DECIMAL_EN
      d_q         <= d_d;
`endif
    end
  end

  // ALU drive depends only on registered state, keeping the external ALU loop-free
  always_comb begin
    alu_ctrl  = ALU_SUM;
    alu_AI    = '0;
    alu_BI    = '0;
    alu_carry = 1'b0;
    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_ADC: begin alu_AI = a_q; alu_BI = b_q;  alu_carry = c_q;  end
        OP_SBC: begin alu_AI = a_q; alu_BI = ~b_q; alu_carry = c_q;  end
        OP_CMP: begin alu_AI = a_q; alu_BI = ~b_q; alu_carry = 1'b1; end
        OP_AND: begin alu_ctrl = ALU_AND; alu_AI = a_q; alu_BI = b_q; end
        OP_ORA: begin alu_ctrl = ALU_OR;  alu_AI = a_q; alu_BI = b_q; end
        OP_EOR: begin alu_ctrl = ALU_XOR; alu_AI = a_q; alu_BI = b_q; end
        OP_ASL: begin alu_AI = a_q; alu_BI = a_q; end
        OP_ROL: begin alu_AI = a_q; alu_BI = a_q; alu_carry = c_q; end
        OP_LSR: begin alu_ctrl = ALU_SR; alu_AI = a_q; end
        OP_ROR: begin alu_ctrl = ALU_SR; alu_AI = a_q; alu_carry = c_q; end
        default: ;
      endcase
    end
`ifdef ALU_SEQ_DECIMAL_EN
    else if (state_q == ST_ADJ) begin
      alu_AI = res_data_q;
      alu_BI = adj_corr;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
`ifdef ALU_SEQ_DECIMAL_EN
    d_d         = d_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d    = op_code;
          a_d     = op_a;
          b_d     = op_b;
          c_d     = op_carry;
`ifdef ALU_SEQ_DECIMAL_EN
          d_d     = op_decimal;
`endif
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_data_d             = alu_Y;
        res_flags_d            = '0;
        res_flags_d[FLAG_NEG]  = alu_Y[DW-1];
        res_flags_d[FLAG_ZERO] = (alu_Y == '0);
        case (op_q)
          OP_ADC, OP_SBC: begin
            res_flags_d[FLAG_CARRY] = alu_flags[0];
            res_flags_d[FLAG_OFV]   = (a_q[DW-1] == b7_eff) & (alu_Y[DW-1] != a_q[DW-1]);
          end
          OP_CMP: begin
            res_data_d              = a_q;
            res_flags_d[FLAG_CARRY] = alu_flags[0];
          end
          OP_ASL, OP_ROL: res_flags_d[FLAG_CARRY] = alu_flags[0];
          OP_LSR, OP_ROR: res_flags_d[FLAG_CARRY] = a_q[0];
          OP_AND, OP_ORA, OP_EOR: ;
          default: begin
            res_data_d  = '0;
            res_flags_d = '0;
          end
        endcase
        state_d = dec_op ? ST_ADJ : ST_DONE;
      end
`ifdef ALU_SEQ_DECIMAL_EN
      ST_ADJ: begin
        // V is kept from the binary pass
        res_data_d              = alu_Y;
        res_flags_d[FLAG_NEG]   = alu_Y[DW-1];
        res_flags_d[FLAG_ZERO]  = (alu_Y == '0);
        res_flags_d[FLAG_CARRY] = adj_carry;
        state_d                 = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign alu_DAA   = 1'b0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU; expectations adapt
// to whether ALU_SEQ_DECIMAL_EN is defined for the build.
`timescale 1ns/1ps
module tb_alu_sequencer;

`ifdef ALU_SEQ_DECIMAL_EN
  localparam int         LAT_D   = 3;
  localparam logic [7:0] V2_DATA = 8'h05;
  localparam logic [7:0] V2_FLGS = 8'h41;
  localparam logic [7:0] V4_DATA = 8'h91;
`else
  localparam int         LAT_D   = 2;
  localparam logic [7:0] V2_DATA = 8'h9F;
  localparam logic [7:0] V2_FLGS = 8'hC0;
  localparam logic [7:0] V4_DATA = 8'hF1;
`endif

  logic       clk, reset;
  logic       op_valid, op_ready;
  logic [3:0] op_code;
  logic [7:0] op_a, op_b;
  logic       op_carry, op_decimal;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_AI, alu_BI;
  logic       alu_carry, alu_DAA;
  logic [7:0] alu_Y, alu_flags;
  logic       res_valid, res_ready;
  logic [7:0] res_data, res_flags;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_carry(op_carry), .op_decimal(op_decimal),
    .alu_ctrl(alu_ctrl), .alu_AI(alu_AI), .alu_BI(alu_BI),
    .alu_carry(alu_carry), .alu_DAA(alu_DAA),
    .alu_Y(alu_Y), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum   = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'd0, alu_carry};
    alu_Y     = 8'h00;
    alu_flags = 8'h00;
    case (alu_ctrl)
      3'b000: begin alu_Y = alu_sum[7:0]; alu_flags[0] = alu_sum[8]; end
      3'b001: alu_Y = alu_AI | alu_BI;
      3'b010: alu_Y = alu_AI ^ alu_BI;
      3'b011: alu_Y = alu_AI & alu_BI;
      3'b100: begin alu_Y = {alu_carry, alu_AI[7:1]}; alu_flags[0] = alu_AI[0]; end
      default: ;
    endcase
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] flags;
    int         lat;
    int         hold;
    int         id;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic d, input logic [7:0] e_data, input logic [7:0] e_flags,
                       input int lat, input int hold, input bit push,
                       input logic [2:0] e_ctrl, input logic [7:0] e_ai, input logic [7:0] e_bi,
                       input logic e_cin);
    exp_t e;
    int   guard = 0;
    while (op_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("v%0d_op_ready", id), {31'b0, op_ready}, 32'd1);
    op_code = op; op_a = a; op_b = b; op_carry = c; op_decimal = d;
    op_valid = 1'b1;
    if (push) begin
      e.data = e_data; e.flags = e_flags; e.lat = lat; e.hold = hold; e.id = id; e.acc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    op_valid = 1'b0;
    check($sformatf("v%0d_exec_ctrl", id), {29'b0, alu_ctrl}, {29'b0, e_ctrl});
    check($sformatf("v%0d_exec_ai", id), {24'b0, alu_AI}, {24'b0, e_ai});
    check($sformatf("v%0d_exec_bi", id), {24'b0, alu_BI}, {24'b0, e_bi});
    check($sformatf("v%0d_exec_cin", id), {31'b0, alu_carry}, {31'b0, e_cin});
  endtask

  initial begin : monitor
    exp_t e;
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", {31'b0, res_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d_latency", e.id), cyc - e.acc, e.lat);
          check($sformatf("v%0d_data", e.id), {24'b0, res_data}, {24'b0, e.data});
          check($sformatf("v%0d_flags", e.id), {24'b0, res_flags}, {24'b0, e.flags});
          check($sformatf("v%0d_busy", e.id), {31'b0, op_ready}, 32'd0);
          $display("vec %0d: data=%02h flags=%02h latency=%0d", e.id, res_data, res_flags, cyc - e.acc);
          for (int i = 0; i < e.hold; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_hold_valid", e.id), {31'b0, res_valid}, 32'd1);
            check($sformatf("v%0d_hold_data", e.id), {24'b0, res_data}, {24'b0, e.data});
            check($sformatf("v%0d_hold_flags", e.id), {24'b0, res_flags}, {24'b0, e.flags});
            check($sformatf("v%0d_hold_busy", e.id), {31'b0, op_ready}, 32'd0);
          end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("post_hs_valid", {31'b0, res_valid}, 32'd0);
        check("post_hs_ready", {31'b0, op_ready}, 32'd1);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || mon_busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin : stimulus
    reset = 1'b1; op_valid = 1'b0; op_code = 4'd0; op_a = 8'h00; op_b = 8'h00;
    op_carry = 1'b0; op_decimal = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_op_ready", {31'b0, op_ready}, 32'd1);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_res_data", {24'b0, res_data}, 32'd0);
    check("rst_res_flags", {24'b0, res_flags}, 32'd0);
    check("rst_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
    check("rst_alu_ai", {24'b0, alu_AI}, 32'd0);
    check("rst_alu_bi", {24'b0, alu_BI}, 32'd0);
    check("rst_alu_carry", {31'b0, alu_carry}, 32'd0);
    check("rst_alu_daa", {31'b0, alu_DAA}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    //     id op     A      B      C     D     data     flags    lat    hold push ctrl  AI     BI     Cin
    issue(1, 4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0,   8'hC0,   2,     0, 1, 3'd0, 8'h50, 8'h50, 1'b0);
    issue(2, 4'd0, 8'h58, 8'h46, 1'b1, 1'b1, V2_DATA, V2_FLGS, LAT_D, 0, 1, 3'd0, 8'h58, 8'h46, 1'b1);
`ifdef ALU_SEQ_DECIMAL_EN
    @(negedge clk);
    check("v2_adj_ctrl", {29'b0, alu_ctrl}, 32'd0);
    check("v2_adj_ai", {24'b0, alu_AI}, 32'h9F);
    check("v2_adj_bi", {24'b0, alu_BI}, 32'h66);
    check("v2_adj_cin", {31'b0, alu_carry}, 32'd0);
`endif
    issue(3,  4'd1,  8'h46, 8'h12, 1'b1, 1'b1, 8'h34,   8'h01, LAT_D, 0, 1, 3'd0, 8'h46, 8'hED, 1'b1);
    issue(4,  4'd1,  8'h12, 8'h21, 1'b1, 1'b1, V4_DATA, 8'h80, LAT_D, 0, 1, 3'd0, 8'h12, 8'hDE, 1'b1);
    issue(5,  4'd5,  8'h10, 8'h20, 1'b0, 1'b0, 8'h10,   8'h80, 2,     0, 1, 3'd0, 8'h10, 8'hDF, 1'b1);
    issue(6,  4'd5,  8'h20, 8'h20, 1'b0, 1'b1, 8'h20,   8'h03, 2,     0, 1, 3'd0, 8'h20, 8'hDF, 1'b1);
    issue(7,  4'd9,  8'h01, 8'h00, 1'b1, 1'b0, 8'h80,   8'h81, 2,     0, 1, 3'd4, 8'h01, 8'h00, 1'b1);
    issue(8,  4'd6,  8'h80, 8'h00, 1'b1, 1'b0, 8'h00,   8'h03, 2,     0, 1, 3'd0, 8'h80, 8'h80, 1'b0);
    issue(9,  4'd2,  8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30,   8'h00, 2,     0, 1, 3'd3, 8'hF0, 8'h3C, 1'b0);
    issue(10, 4'd3,  8'h80, 8'h01, 1'b0, 1'b0, 8'h81,   8'h80, 2,     0, 1, 3'd1, 8'h80, 8'h01, 1'b0);
    issue(11, 4'd4,  8'h5A, 8'h5A, 1'b0, 1'b0, 8'h00,   8'h02, 2,     0, 1, 3'd2, 8'h5A, 8'h5A, 1'b0);
    issue(12, 4'd7,  8'h81, 8'h00, 1'b1, 1'b0, 8'h40,   8'h01, 2,     0, 1, 3'd4, 8'h81, 8'h00, 1'b0);
    issue(13, 4'd8,  8'h80, 8'h00, 1'b1, 1'b0, 8'h01,   8'h01, 2,     0, 1, 3'd0, 8'h80, 8'h80, 1'b1);
    issue(14, 4'd12, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00,   8'h00, 2,     0, 1, 3'd0, 8'h00, 8'h00, 1'b0);
    issue(15, 4'd1,  8'h80, 8'h01, 1'b1, 1'b0, 8'h7F,   8'h41, 2,     0, 1, 3'd0, 8'h80, 8'hFE, 1'b1);
    issue(16, 4'd0,  8'h01, 8'h01, 1'b0, 1'b0, 8'h02,   8'h00, 2,     5, 1, 3'd0, 8'h01, 8'h01, 1'b0);
    drain("drain_main");

    // Reset while the operation is in flight: no result may ever appear
    issue(17, 4'd0, 8'h58, 8'h46, 1'b1, 1'b1, 8'h00, 8'h00, 0, 0, 0, 3'd0, 8'h58, 8'h46, 1'b1);
`ifdef ALU_SEQ_DECIMAL_EN
    @(negedge clk);
    check("v17_adj_bi", {24'b0, alu_BI}, 32'h66);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("v17_rst_op_ready", {31'b0, op_ready}, 32'd1);
    check("v17_rst_res_valid", {31'b0, res_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("v17_no_result_%0d", i), {31'b0, res_valid}, 32'd0);
    end
    drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
